fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch FSM feeding a DEPTH-entry FIFO; one request in flight, one word per cycle on a zero-wait bus.
// Entries appear on out_* the cycle after the response; fetch stalls while the queue is full.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         ireq_valid,
  output logic [63:0]                  ireq_addr,
  input  logic                         iresp_data_ok,
  input  logic [31:0]                  iresp_data,
  input  logic                         redirect,
  input  logic [63:0]                  redirect_pc,
  output logic                         out_valid,
  output logic [63:0]                  out_pc,
  output logic [31:0]                  out_instr,
  output logic                         out_misaligned,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP, FAULT} state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } entry_t;

  state_e          state_q, state_d;
  logic [63:0]     fpc_q, fpc_d;
  logic [63:0]     drop_addr_q, drop_addr_d;
  logic            fault_done_q, fault_done_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, cnt_next;
  entry_t          mem_q [DEPTH];
  entry_t          head, push_dat;
  logic            push, pop;
  logic [63:0]     fpc_inc;

  assign head           = mem_q[head_q];
  assign count          = count_q;
  assign out_valid      = (count_q != '0);
  assign out_pc         = head.pc;
  assign out_instr      = head.instr;
  assign out_misaligned = out_valid & head.misaligned;

  assign pop      = out_valid & out_ready & ~redirect;
  assign cnt_next = count_q + CW'(push) - CW'(pop);
  assign fpc_inc  = fpc_q + 64'd4;

  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    drop_addr_d  = drop_addr_q;
    fault_done_d = fault_done_q;
    push         = 1'b0;
    push_dat     = '{pc: fpc_q, instr: iresp_data, misaligned: 1'b0};
    ireq_valid   = 1'b0;
    ireq_addr    = fpc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fpc_d = redirect_pc;
        end else if (count_q < CW'(DEPTH)) begin
          state_d      = (fpc_q[1:0] == 2'b00) ? REQ : FAULT;
          fault_done_d = 1'b0;
        end
      end
      REQ: begin
        ireq_valid = 1'b1;
        if (redirect) begin
          fpc_d       = redirect_pc;
          drop_addr_d = fpc_q;
          state_d     = iresp_data_ok ? IDLE : DROP;
        end else if (iresp_data_ok) begin
          push  = 1'b1;
          fpc_d = fpc_inc;
          if (!(cnt_next < CW'(DEPTH) && fpc_inc[1:0] == 2'b00)) state_d = IDLE;
        end
      end
      DROP: begin
        // Bus still owes us the abandoned response; keep its address stable.
        ireq_valid = 1'b1;
        ireq_addr  = drop_addr_q;
        if (redirect)      fpc_d   = redirect_pc;
        if (iresp_data_ok) state_d = IDLE;
      end
      FAULT: begin
        if (redirect) begin
          fpc_d   = redirect_pc;
          state_d = IDLE;
        end else if (!fault_done_q) begin
          push         = 1'b1;
          push_dat     = '{pc: fpc_q, instr: 32'h0, misaligned: 1'b1};
          fault_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fpc_q        <= RESET_PC;
      drop_addr_q  <= '0;
      fault_done_q <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      drop_addr_q  <= drop_addr_d;
      fault_done_q <= fault_done_d;
      if (redirect) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PW'(1);
        if (pop)  head_q <= head_q + PW'(1);
        count_q <= cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[tail_q] <= push_dat;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written redirect/fault/reset sequences, randomized run vs queue model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misaligned;
  logic        out_ready;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_misaligned(out_misaligned), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic rd, input logic [63:0] rp, input logic ok,
                      input logic [31:0] d, input logic rdy);
    redirect = rd; redirect_pc = rp; iresp_data_ok = ok; iresp_data = d; out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset with a redirect and handshakes asserted to show reset wins.
  task automatic do_reset();
    reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h8000_5000;
    iresp_data_ok = 1'b1; iresp_data = 32'hFFFF_FFFF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ivld", ireq_valid, 0);
    chk("rst_ovld", out_valid, 0);
    chk("rst_cnt", count, 0);
    chk("rst_mis", out_misaligned, 0);
    reset = 1'b0; redirect = 1'b0; iresp_data_ok = 1'b0; out_ready = 1'b0;
  endtask

  typedef struct {
    bit          ok;
    bit          rdy;
    bit          ivld;
    logic [63:0] addr;
    bit          ovld;
    logic [63:0] opc;
    logic [31:0] ins;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  // Reference model: the queue contents plus the bus-side bookkeeping.
  ent_t        m_q[$];
  logic [63:0] m_fpc, m_stale_addr;
  bit          m_busy, m_stale, m_faulted, m_sent;

  task automatic model_step(input bit rd, input logic [63:0] rp, input bit ok,
                            input logic [31:0] d, input bit rdy);
    int cnt0 = m_q.size();
    bit pop  = (cnt0 != 0) && rdy && !rd;
    if (rd) begin
      if (m_busy && !ok) begin
        if (!m_stale) m_stale_addr = m_fpc;
        m_stale = 1;
      end else begin
        m_busy = 0; m_stale = 0;
      end
      m_q.delete();
      m_fpc = rp; m_faulted = 0; m_sent = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_busy) begin
        if (ok) begin
          if (!m_stale) begin
            m_q.push_back('{pc: m_fpc, instr: d, mis: 1'b0});
            m_fpc  = m_fpc + 64'd4;
            m_busy = (m_q.size() < DEPTH) && (m_fpc[1:0] == 2'b00);
          end else begin
            m_busy = 0;
          end
          m_stale = 0;
        end
      end else if (m_faulted) begin
        if (!m_sent) begin
          m_q.push_back('{pc: m_fpc, instr: 32'h0, mis: 1'b1});
          m_sent = 1;
        end
      end else if (cnt0 < DEPTH) begin
        if (m_fpc[1:0] == 2'b00) m_busy = 1;
        else begin m_faulted = 1; m_sent = 0; end
      end
    end
  endtask

  vec_t tbl[14];

  initial begin
    logic [63:0] rp;
    bit rd, ok, rdy;
    int okp, rdp;

    tbl[0]  = '{1, 1, 0, 64'h0,           0, 64'h0,           32'h0,         0};
    tbl[1]  = '{1, 1, 1, 64'h8000_0000,   0, 64'h0,           32'h0,         0};
    tbl[2]  = '{1, 1, 1, 64'h8000_0004,   1, 64'h8000_0000,   32'hA000_0001, 1};
    tbl[3]  = '{1, 1, 1, 64'h8000_0008,   1, 64'h8000_0004,   32'hA000_0002, 1};
    tbl[4]  = '{1, 1, 1, 64'h8000_000C,   1, 64'h8000_0008,   32'hA000_0003, 1};
    tbl[5]  = '{1, 0, 1, 64'h8000_0010,   1, 64'h8000_000C,   32'hA000_0004, 1};
    tbl[6]  = '{1, 0, 1, 64'h8000_0014,   1, 64'h8000_000C,   32'hA000_0004, 2};
    tbl[7]  = '{1, 0, 1, 64'h8000_0018,   1, 64'h8000_000C,   32'hA000_0004, 3};
    tbl[8]  = '{1, 0, 0, 64'h0,           1, 64'h8000_000C,   32'hA000_0004, 4};
    tbl[9]  = '{1, 1, 0, 64'h0,           1, 64'h8000_000C,   32'hA000_0004, 4};
    tbl[10] = '{1, 1, 0, 64'h0,           1, 64'h8000_0010,   32'hA000_0005, 3};
    tbl[11] = '{1, 1, 1, 64'h8000_001C,   1, 64'h8000_0014,   32'hA000_0006, 2};
    tbl[12] = '{1, 1, 1, 64'h8000_0020,   1, 64'h8000_0018,   32'hA000_0007, 2};
    tbl[13] = '{1, 1, 1, 64'h8000_0024,   1, 64'h8000_001C,   32'hA000_000B, 2};

    // Streaming, then backpressure to a full queue, then resume.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("tbl%0d_ivld", i), ireq_valid, tbl[i].ivld);
      if (tbl[i].ivld) chk($sformatf("tbl%0d_addr", i), ireq_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_ovld", i), out_valid, tbl[i].ovld);
      if (tbl[i].ovld) begin
        chk($sformatf("tbl%0d_opc", i), out_pc, tbl[i].opc);
        chk($sformatf("tbl%0d_ins", i), out_instr, tbl[i].ins);
      end
      chk($sformatf("tbl%0d_cnt", i), count, tbl[i].cnt);
      tick(0, 0, tbl[i].ok, 32'hA000_0000 + i, tbl[i].rdy);
    end

    // Redirect while a request waits: stale response dropped.
    do_reset();
    chk("drop_idle", ireq_valid, 0);
    tick(0, 0, 0, 0, 0);
    chk("drop_req", ireq_addr, 64'h8000_0000);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 64'h8000_1000, 0, 0, 0);
    chk("drop_ivld", ireq_valid, 1);
    chk("drop_addr", ireq_addr, 64'h8000_0000);
    chk("drop_cnt", count, 0);
    tick(0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("drop_done_ivld", ireq_valid, 0);
    chk("drop_done_cnt", count, 0);
    tick(0, 0, 0, 0, 0);
    chk("redir_addr", ireq_addr, 64'h8000_1000);
    tick(0, 0, 1, 32'h1234_5678, 0);
    chk("redir_opc", out_pc, 64'h8000_1000);
    chk("redir_ins", out_instr, 32'h1234_5678);
    chk("redir_cnt", count, 1);

    // Redirect with same-cycle response to a misaligned PC.
    tick(1, 64'h8000_1002, 1, 32'hFFFF_FFFF, 0);
    chk("mis_cnt0", count, 0);
    chk("mis_ivld0", ireq_valid, 0);
    tick(0, 0, 0, 0, 0);
    chk("mis_ivld1", ireq_valid, 0);
    tick(0, 0, 0, 0, 0);
    chk("mis_cnt", count, 1);
    chk("mis_opc", out_pc, 64'h8000_1002);
    chk("mis_ins", out_instr, 0);
    chk("mis_flag", out_misaligned, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 32'h5, 0);
      chk("mis_hold_cnt", count, 1);
      chk("mis_hold_ivld", ireq_valid, 0);
    end
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("mis_after_cnt", count, 0);
      chk("mis_after_ivld", ireq_valid, 0);
      tick(0, 0, 0, 0, 0);
    end
    tick(1, 64'h8000_2000, 0, 0, 0);
    chk("unfault_idle", ireq_valid, 0);
    tick(0, 0, 0, 0, 0);
    chk("unfault_addr", ireq_addr, 64'h8000_2000);
    chk("unfault_ivld", ireq_valid, 1);

    // Full queue, then redirect + pop + data_ok together.
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 32'h700 + i, 0);
    chk("full_cnt", count, 4);
    chk("full_ivld", ireq_valid, 0);
    chk("full_head", out_instr, 32'h700);
    tick(1, 64'h8000_3000, 1, 32'hBAD0_0000, 1);
    chk("flush_cnt", count, 0);
    chk("flush_ovld", out_valid, 0);
    tick(0, 0, 0, 0, 0);
    chk("flush_addr", ireq_addr, 64'h8000_3000);
    tick(0, 0, 1, 32'h5555_AAAA, 0);
    chk("flush_opc", out_pc, 64'h8000_3000);
    chk("flush_ins", out_instr, 32'h5555_AAAA);
    chk("flush_cnt1", count, 1);

    // Reset in DROP: pending drop cancelled, late response ignored.
    tick(1, 64'h8000_4000, 0, 0, 0);
    chk("rd_drop_addr", ireq_addr, 64'h8000_3004);
    do_reset();
    chk("rd_idle_ivld", ireq_valid, 0);
    tick(0, 0, 1, 32'hBAD0_0001, 0);
    chk("rd_req_addr", ireq_addr, 64'h8000_0000);
    chk("rd_req_cnt", count, 0);
    tick(0, 0, 1, 32'h0000_0013, 0);
    chk("rd_opc", out_pc, 64'h8000_0000);
    chk("rd_ins", out_instr, 32'h0000_0013);

    // Randomized run against the model.
    do_reset();
    m_q.delete();
    m_fpc = RPC; m_busy = 0; m_stale = 0; m_faulted = 0; m_sent = 0; m_stale_addr = '0;
    okp = 50; rdp = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        okp = $urandom_range(20, 100);
        rdp = $urandom_range(10, 100);
      end
      chk("rnd_ivld", ireq_valid, m_busy);
      if (m_busy) chk("rnd_addr", ireq_addr, m_stale ? m_stale_addr : m_fpc);
      chk("rnd_ovld", out_valid, m_q.size() != 0);
      chk("rnd_cnt", count, m_q.size());
      chk("rnd_mis", out_misaligned, (m_q.size() != 0) ? m_q[0].mis : 1'b0);
      if (m_q.size() != 0) begin
        chk("rnd_opc", out_pc, m_q[0].pc);
        chk("rnd_ins", out_instr, m_q[0].instr);
      end
      rd  = ($urandom_range(0, 29) == 0);
      ok  = ($urandom_range(0, 99) < okp);
      rdy = ($urandom_range(0, 99) < rdp);
      rp  = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4;
      if ($urandom_range(0, 7) == 0) rp[1] = 1'b1;
      iresp_data = $urandom;
      model_step(rd, rp, ok, iresp_data, rdy);
      tick(rd, rp, ok, iresp_data, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
